// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Frame length math lives here so the drain counter and any model agree.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN
    } state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] STOP_MIN    = 2'd1;

    // Start + data + optional parity + stop bits; a zero stop count means one.
    function automatic int frame_bits(
        input logic [1:0] parity,
        input logic [1:0] stop,
        input int         dw
    );
        int fb;
        fb = 1 + dw;
        if (parity != PARITY_NONE) fb = fb + 1;
        if (stop == 2'd0) fb = fb + int'(STOP_MIN);
        else fb = fb + int'(stop);
        return fb;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick over a request vector starting at a stored pointer.
// The pointer moves to one past the finishing owner when advance pulses.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic                       advance,
    input  logic [$clog2(N_REQ)-1:0]   last,
    output logic [$clog2(N_REQ)-1:0]   idx,
    output logic                       any
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] ptr;

    always_comb begin
        int j;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            if (int'(last) == N_REQ - 1) ptr <= '0;
            else ptr <= last + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between N_REQ AXI-Stream sources, each with
// its own line settings, switching owner only after the line goes quiet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DEF_DELITEL = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N_REQ-1:0]              s_tvalid,
    input  logic [N_REQ-1:0]              s_tlast,
    output logic [N_REQ-1:0]              s_tready,
    input  logic [N_REQ*32-1:0]           cfg_delitel,
    input  logic [N_REQ*2-1:0]            cfg_parity,
    input  logic [N_REQ*2-1:0]            cfg_stop,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [31:0]                   delitel,
    output logic [31:0]                   parity_bit_mode,
    output logic [31:0]                   stop_bit_num,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(N_REQ);

    state_t        state;
    logic [31:0]   sh_delitel;
    logic [1:0]    sh_parity;
    logic [1:0]    sh_stop;
    logic [31:0]   cyc_cnt;
    logic [7:0]    bit_cnt;
    logic [31:0]   div;
    logic [7:0]    fb;
    logic          drain_done;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic [1:0]    win_stop;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (s_tvalid),
        .advance(drain_done),
        .last   (grant_id),
        .idx    (win_idx),
        .any    (win_any)
    );

    // A zero divisor still takes one clock per bit on the wire.
    assign div        = (sh_delitel == 32'd0) ? 32'd1 : sh_delitel;
    assign fb         = 8'(frame_bits(sh_parity, sh_stop, DATA_WIDTH));
    assign drain_done = (state == DRAIN) && (cyc_cnt == div - 32'd1)
                        && (bit_cnt == fb);
    assign win_stop   = cfg_stop[win_idx*2 +: 2];

    assign delitel         = sh_delitel;
    assign parity_bit_mode = {30'd0, sh_parity};
    assign stop_bit_num    = {30'd0, sh_stop};
    assign busy            = (state != IDLE);

    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_data   = '0;
        if (state == GRANT) begin
            s_tready[grant_id] = m_tready;
            m_tvalid           = s_tvalid[grant_id];
            m_data = s_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            sh_delitel <= 32'(DEF_DELITEL);
            sh_parity  <= PARITY_NONE;
            sh_stop    <= STOP_MIN;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        grant_id   <= win_idx;
                        sh_delitel <= cfg_delitel[win_idx*32 +: 32];
                        sh_parity  <= cfg_parity[win_idx*2 +: 2];
                        sh_stop    <= (win_stop == 2'd0) ? STOP_MIN
                                                         : win_stop;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (s_tvalid[grant_id] && m_tready
                        && s_tlast[grant_id]) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // One extra bit time covers the transmitter's own latency.
                    if (cyc_cnt == div - 32'd1) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == fb) state <= IDLE;
                        else bit_cnt <= bit_cnt + 8'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted requesters, a beat log
// and hand-computed expectations for timing and ownership.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [N*32-1:0] cfg_delitel;
    logic [N*2-1:0]  cfg_parity;
    logic [N*2-1:0]  cfg_stop;
    logic [DW-1:0]   m_data;
    logic            m_tvalid;
    logic            m_tready;
    logic [31:0]     delitel;
    logic [31:0]     parity_bit_mode;
    logic [31:0]     stop_bit_num;
    logic [1:0]      grant_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    int           pk_len[N];
    int           pk_pos[N];
    int           pk_base[N];
    logic [N-1:0] act;
    logic [N-1:0] hold;

    logic [1:0]  q_id[$];
    logic [7:0]  q_dat[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(DW),
        .DEF_DELITEL(868)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .cfg_delitel    (cfg_delitel),
        .cfg_parity     (cfg_parity),
        .cfg_stop       (cfg_stop),
        .m_data         (m_data),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .delitel        (delitel),
        .parity_bit_mode(parity_bit_mode),
        .stop_bit_num   (stop_bit_num),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always @(posedge clk) begin
        if (m_tvalid && m_tready) begin
            q_id.push_back(grant_id);
            q_dat.push_back(m_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input int k, input int id, input int d);
        logic [31:0] obs;
        obs = 32'hFFFF;
        if (k < q_dat.size()) obs = {22'd0, q_id[k], q_dat[k]};
        chk($sformatf("log%0d", k), obs, 32'((id << 8) | d));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]        = act[i] & ~hold[i];
            s_tdata[i*DW +: DW] = DW'(pk_base[i] + pk_pos[i]);
            s_tlast[i]         = (pk_pos[i] == pk_len[i] - 1);
        end
        #1;
    endtask

    task automatic start(input int i, input int len, input int base);
        pk_len[i]  = len;
        pk_pos[i]  = 0;
        pk_base[i] = base;
        act[i]     = 1'b1;
        drive();
    endtask

    task automatic set_cfg(input int i, input int d, input int p,
                           input int s);
        cfg_delitel[i*32 +: 32] = 32'(d);
        cfg_parity[i*2 +: 2]    = 2'(p);
        cfg_stop[i*2 +: 2]      = 2'(s);
    endtask

    task automatic run_cycles(input int n);
        logic [N-1:0] hs;
        repeat (n) begin
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    pk_pos[i]++;
                    if (pk_pos[i] == pk_len[i]) act[i] = 1'b0;
                end
            end
            drive();
        end
    endtask

    task automatic run_until_idle(input string tag, input int limit);
        int c;
        c = 0;
        while ((busy || act != '0) && c < limit) begin
            run_cycles(1);
            c++;
        end
        chk(tag, 32'(c < limit), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        chk({tag, "_div"}, delitel, 32'd868);
        chk({tag, "_par"}, parity_bit_mode, 32'd0);
        chk({tag, "_stop"}, stop_bit_num, 32'd1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        m_tready = 1'b0;
        act = '0;
        hold = '0;
        s_tdata = '0;
        s_tvalid = '0;
        s_tlast = '0;
        for (int i = 0; i < N; i++) begin
            pk_len[i] = 1;
            pk_pos[i] = 0;
            pk_base[i] = 0;
            set_cfg(i, 1, 0, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        chk_reset_vals("rst");

        // Single byte from requester 2, transmitter stalls one cycle.
        set_cfg(2, 10, 0, 1);
        start(2, 1, 8'hA5);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        run_cycles(1);
        chk("t1_gid", 32'(grant_id), 32'd2);
        chk("t1_tvalid", 32'(m_tvalid), 32'd1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_tready0", 32'(s_tready), 32'd0);
        chk("t1_div", delitel, 32'd10);
        cnt = 1;
        run_cycles(1);
        m_tready = 1'b1;
        #1;
        chk("t1_tready", 32'(s_tready), 32'b0100);
        while (busy && cnt < 500) begin
            cnt++;
            run_cycles(1);
        end
        chk("t1_busy_len", 32'(cnt), 32'd112);
        chk("t1_div_hold", delitel, 32'd10);
        chk_log(0, 2, 8'hA5);

        // Two 3-byte packets, no interleaving; then a 4-way round.
        set_cfg(2, 1, 0, 1);
        q_id.delete();
        q_dat.delete();
        start(0, 3, 8'h10);
        start(1, 3, 8'h20);
        run_until_idle("t2_timeout", 2000);
        chk("t2_count", 32'(q_dat.size()), 32'd6);
        for (int k = 0; k < 3; k++) chk_log(k, 0, 8'h10 + k);
        for (int k = 0; k < 3; k++) chk_log(k + 3, 1, 8'h20 + k);
        q_id.delete();
        q_dat.delete();
        for (int i = 0; i < N; i++) start(i, 1, 8'h70 + i);
        run_until_idle("t2b_timeout", 2000);
        chk_log(0, 2, 8'h72);
        chk_log(1, 3, 8'h73);
        chk_log(2, 0, 8'h70);
        chk_log(3, 1, 8'h71);

        // Config switch only after the 65-cycle drain of requester 1.
        set_cfg(1, 5, 1, 2);
        set_cfg(3, 20, 0, 1);
        start(1, 1, 8'h31);
        run_cycles(1);
        chk("t3_gid1", 32'(grant_id), 32'd1);
        chk("t3_div1", delitel, 32'd5);
        chk("t3_par1", parity_bit_mode, 32'd1);
        chk("t3_stop1", stop_bit_num, 32'd2);
        start(3, 1, 8'h33);
        cnt = 0;
        while (delitel == 32'd5 && cnt < 200) begin
            run_cycles(1);
            cnt++;
        end
        chk("t3_switch", 32'(cnt), 32'd67);
        chk("t3_gid3", 32'(grant_id), 32'd3);
        chk("t3_div3", delitel, 32'd20);
        run_until_idle("t3_timeout", 2000);

        // Owner pauses 50 cycles mid-packet while another is waiting.
        q_id.delete();
        q_dat.delete();
        start(2, 3, 8'h40);
        run_cycles(2);
        hold[2] = 1'b1;
        start(0, 1, 8'h50);
        run_cycles(50);
        chk("t4_gid", 32'(grant_id), 32'd2);
        chk("t4_tvalid", 32'(m_tvalid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        hold[2] = 1'b0;
        drive();
        run_until_idle("t4_timeout", 2000);
        chk("t4_count", 32'(q_dat.size()), 32'd4);
        for (int k = 0; k < 3; k++) chk_log(k, 2, 8'h40 + k);
        chk_log(3, 0, 8'h50);

        // Zero divisor and zero stop count.
        set_cfg(1, 0, 0, 0);
        start(1, 1, 8'h55);
        run_cycles(1);
        chk("t5_gid", 32'(grant_id), 32'd1);
        chk("t5_div", delitel, 32'd0);
        chk("t5_stop", stop_bit_num, 32'd1);
        run_cycles(1);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            run_cycles(1);
        end
        chk("t5_drain", 32'(cnt), 32'd11);

        // Reset in the middle of a 4-beat packet.
        start(2, 4, 8'h60);
        run_cycles(2);
        chk("t6_gid", 32'(grant_id), 32'd2);
        chk("t6_tvalid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        act = '0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        chk_reset_vals("t6");
        start(3, 1, 8'h63);
        start(1, 1, 8'h61);
        run_cycles(1);
        chk("t6_rr_restart", 32'(grant_id), 32'd1);
        run_until_idle("t6_timeout", 2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one `axis_uart_tx` serializer among `N_REQ` AXI-Stream requesters, each with its own UART line settings. It sits between the requesters and the transmitter. It drives the transmitter's `delitel`, `parity_bit_mode` and `stop_bit_num` inputs itself, from per-requester configuration captured at grant time. Settings change only after the last frame of a packet has fully left the line.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, payload bits per UART frame
- `DEF_DELITEL`, 868, divisor driven while no requester owns the transmitter

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `s_tdata` in `N_REQ*DATA_WIDTH`: requester data, requester i at slice i
- `s_tvalid` in `N_REQ`: requester valid
- `s_tlast` in `N_REQ`: last byte of the requester's packet
- `s_tready` out `N_REQ`: ready, one-hot or zero
- `cfg_delitel` in `N_REQ*32`: per-requester clocks per bit
- `cfg_parity` in `N_REQ*2`: per-requester parity mode; 0 = none, 1..3 = parity bit present
- `cfg_stop` in `N_REQ*2`: per-requester stop bits, 1 or 2
- `m_data` out `DATA_WIDTH`: to `saxis_data_i`
- `m_tvalid` out 1: to `saxis_tvalid_i`
- `m_tready` in 1: from `saxis_tready_o`
- `delitel`, `parity_bit_mode`, `stop_bit_num` out 32 each: to the transmitter configuration inputs
- `grant_id` out `$clog2(N_REQ)`: current or most recent owner
- `busy` out 1: high in GRANT and DRAIN

## Operation
States:
- **IDLE**
  - Scan `s_tvalid` round-robin, starting at `rr_ptr`.
  - On any valid: latch the winner's `cfg_*` into shadow registers, set `grant_id`, go to GRANT.
  - No valid: stay in IDLE.
- **GRANT**
  - `m_data = s_tdata[grant_id]`, `m_tvalid = s_tvalid[grant_id]`, `s_tready[grant_id] = m_tready`; all other readies are 0.
  - A handshake with `s_tlast` set goes to DRAIN.
  - `s_tvalid` dropping mid-packet does not release the grant; ownership holds until `tlast`.
- **DRAIN**
  - Wait until the final frame is fully on the wire. Nested counters, no multiplier:
    - `cyc_cnt` counts `max(delitel,1)` cycles per bit.
    - `bit_cnt` counts `FB + 1` bits, where `FB = 1 + DATA_WIDTH + (parity!=0) + stop`.
  - Then set `rr_ptr = grant_id + 1` (mod `N_REQ`) and go to IDLE.
  - `s_tready` and `m_tvalid` are 0 throughout.

Configuration rules:
- Shadow config drives `delitel`, `parity_bit_mode` (zero-extended) and `stop_bit_num` from the GRANT entry until DRAIN exits.
- In IDLE, the outputs keep their last values.
- Configuration inputs changing during GRANT or DRAIN are ignored.
- `cfg_stop` = 0 is treated as 1. `cfg_delitel` = 0 is treated as 1 for counting and is driven unchanged to the transmitter.

Reset values:
- `s_tready` = 0, `m_tvalid` = 0, `m_data` = 0, `busy` = 0
- `grant_id` = 0, `rr_ptr` = 0
- `delitel` = `DEF_DELITEL`, `parity_bit_mode` = 0, `stop_bit_num` = 1

A reset asserted in any state returns the block to IDLE on the next edge. Frames already partially on the line are abandoned.

## Timing
- IDLE→GRANT: 1 cycle after `s_tvalid` is seen. The first `m_tvalid` appears the cycle after the winner is seen.
- Shadow config is valid on the same edge that enters GRANT. Config therefore precedes the first `m_tvalid` by ≥0 cycles and never changes while `m_tvalid` is high.
- GRANT path (`m_tvalid`, `m_data`, `s_tready`) is combinational from the owner's inputs, gated by a registered state and `grant_id`. Zero-latency pass-through, full throughput.
- DRAIN length: exactly `(FB+1)*max(delitel,1)` cycles. Example: `delitel` = 10, no parity, 1 stop → 110 cycles.
- Minimum gap between packets of different owners: DRAIN length + 1 (the IDLE cycle).
- Simultaneous valids: the lowest index ≥ `rr_ptr` (with wrap-around) wins.

## Structure
- Package `uart_pkg`: `state_t` enum (IDLE/GRANT/DRAIN), `PARITY_NONE` = 0, `STOP_MIN` = 1, and function `frame_bits(parity, stop, dw)`.
- Sub-module `rr_arbiter` (request vector, pointer → one-hot grant and index; combinational plus pointer update on enable) is natural.
- Drain counters and shadow registers stay in the top module.

## Test plan
1. After reset: outputs hold their reset values, `delitel` = 868. Requester 2 sends 1 byte with `tlast` (cfg 10/0/1) → `grant_id` = 2, byte appears on `m_data`, `busy` high for 1 + 1 + 110 cycles.
2. Requesters 0 and 1 both send 3-byte packets → requester 0's 3 bytes then requester 1's 3 bytes, never interleaved. `rr_ptr` ends at 2.
3. Requester 1 (cfg 5/1/2) then requester 3 (cfg 20/0/1): `delitel` switches 5→20 only after 5×13 = 65 DRAIN cycles.
4. Owner deasserts `s_tvalid` for 50 cycles mid-packet while requester 0 is valid → grant is held, then the packet completes.
5. `cfg_delitel` = 0, `cfg_stop` = 0 → DRAIN lasts 11 cycles, `stop_bit_num` = 1.
6. `rst` pulsed in GRANT after 1 of 4 beats → next cycle IDLE, all outputs at reset values, round-robin restarts at 0.
